// File: rtl/posit_mul_sched.sv
// Round-robin arbiter sharing one posit multiplier among NREQ requesters.
// One operation in flight; operands held for MUL_LAT+1 cycles, result held until consumed.
module posit_mul_sched #(
    parameter int unsigned N       = 16,
    parameter int unsigned ES      = 3,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned MUL_LAT = 0,
    parameter int unsigned IDW     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_in1,
    input  logic [NREQ*N-1:0] req_in2,
    output logic [NREQ-1:0]   resp_valid,
    input  logic [NREQ-1:0]   resp_ready,
    output logic [N-1:0]      resp_out,
    output logic              resp_inf,
    output logic              resp_zero,
    output logic [N-1:0]      mul_in1,
    output logic [N-1:0]      mul_in2,
    output logic              mul_start,
    input  logic [N-1:0]      mul_out,
    input  logic              mul_inf,
    input  logic              mul_zero,
    output logic              busy,
    output logic [IDW-1:0]    grant_id,
    output logic [31:0]       op_count
);

    localparam int unsigned CW = 3;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Reject configurations the datapath cannot represent
    if (ES >= N || NREQ < 2 || NREQ > 8 || MUL_LAT > 7 || (1 << IDW) < NREQ) begin : g_bad_cfg
        $error("posit_mul_sched: unsupported parameter combination");
    end

    logic [1:0]     state, next_state;
    logic [IDW-1:0] rr_ptr, winner, scan, next_ptr;
    logic           found;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   op_a, op_b, sel_a, sel_b;

    // Winner is the first valid requester at or after rr_ptr, wrapping
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        scan   = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            scan = IDW'((int'(rr_ptr) + k) % int'(NREQ));
            if (req_valid[scan]) begin
                winner = scan;
                found  = 1'b1;
            end
        end
    end

    assign next_ptr = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (winner == IDW'(i)) begin
                sel_a = req_in1[i*N +: N];
                sel_b = req_in2[i*N +: N];
            end
        end
    end

    // Grant is combinational so a requester can be accepted in its first IDLE cycle
    always_comb begin
        req_ready = '0;
        if (state == IDLE && found && !rst) req_ready[winner] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (found) next_state = EXEC;
            EXEC:    if (cnt == CW'(MUL_LAT)) next_state = RESP;
            RESP:    if (resp_ready[grant_id]) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            grant_id   <= '0;
            op_count   <= '0;
            cnt        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            resp_out   <= '0;
            resp_inf   <= 1'b0;
            resp_zero  <= 1'b0;
            resp_valid <= '0;
            mul_start  <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        op_a      <= sel_a;
                        op_b      <= sel_b;
                        grant_id  <= winner;
                        rr_ptr    <= next_ptr;
                        cnt       <= '0;
                        mul_start <= 1'b1;
                    end
                end
                EXEC: begin
                    if (cnt == CW'(MUL_LAT)) begin
                        resp_out   <= mul_out;
                        resp_inf   <= mul_inf;
                        resp_zero  <= mul_zero;
                        resp_valid <= NREQ'(1) << grant_id;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (resp_ready[grant_id]) begin
                        op_count   <= op_count + 32'd1;
                        resp_valid <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mul_in1 = op_a;
    assign mul_in2 = op_b;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_posit_mul_sched.sv
// Directed bench for posit_mul_sched: one combinational-multiplier instance (MUL_LAT=0)
// and one three-stage pipelined instance (MUL_LAT=3), sharing clock and reset.
module tb_posit_mul_sched;

    localparam int unsigned N    = 16;
    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic clk, rst;
    int   checks = 0;
    int   errors = 0;

    logic [NREQ-1:0]   a_req_valid, a_req_ready, a_resp_valid, a_resp_ready;
    logic [NREQ*N-1:0] a_req_in1, a_req_in2;
    logic [N-1:0]      a_resp_out, a_mul_in1, a_mul_in2, a_mul_out;
    logic              a_resp_inf, a_resp_zero, a_mul_start, a_mul_inf, a_mul_zero, a_busy;
    logic [IDW-1:0]    a_grant_id;
    logic [31:0]       a_op_count;

    logic [NREQ-1:0]   b_req_valid, b_req_ready, b_resp_valid, b_resp_ready;
    logic [NREQ*N-1:0] b_req_in1, b_req_in2;
    logic [N-1:0]      b_resp_out, b_mul_in1, b_mul_in2, b_mul_out;
    logic              b_resp_inf, b_resp_zero, b_mul_start, b_mul_inf, b_mul_zero, b_busy;
    logic [IDW-1:0]    b_grant_id;
    logic [31:0]       b_op_count;
    logic [17:0]       p1, p2, p3;

    // Stub multiplier: NaR and zero propagate, 1.0 (0x4000) is the identity, else a fixed scramble
    function automatic logic [17:0] pmul(input logic [15:0] x, input logic [15:0] y);
        if (x == 16'h8000 || y == 16'h8000) return {2'b10, 16'h8000};
        if (x == 16'h0000 || y == 16'h0000) return {2'b01, 16'h0000};
        if (x == 16'h4000) return {2'b00, y};
        if (y == 16'h4000) return {2'b00, x};
        return {2'b00, x ^ {y[7:0], y[15:8]}};
    endfunction

    assign {a_mul_inf, a_mul_zero, a_mul_out} = pmul(a_mul_in1, a_mul_in2);

    always @(posedge clk) begin
        p1 <= pmul(b_mul_in1, b_mul_in2);
        p2 <= p1;
        p3 <= p2;
    end
    assign {b_mul_inf, b_mul_zero, b_mul_out} = p3;

    posit_mul_sched #(.N(16), .ES(3), .NREQ(4), .MUL_LAT(0), .IDW(2)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_in1(a_req_in1), .req_in2(a_req_in2),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_out(a_resp_out), .resp_inf(a_resp_inf), .resp_zero(a_resp_zero),
        .mul_in1(a_mul_in1), .mul_in2(a_mul_in2), .mul_start(a_mul_start),
        .mul_out(a_mul_out), .mul_inf(a_mul_inf), .mul_zero(a_mul_zero),
        .busy(a_busy), .grant_id(a_grant_id), .op_count(a_op_count)
    );

    posit_mul_sched #(.N(16), .ES(3), .NREQ(4), .MUL_LAT(3), .IDW(2)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_in1(b_req_in1), .req_in2(b_req_in2),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_out(b_resp_out), .resp_inf(b_resp_inf), .resp_zero(b_resp_zero),
        .mul_in1(b_mul_in1), .mul_in2(b_mul_in2), .mul_start(b_mul_start),
        .mul_out(b_mul_out), .mul_inf(b_mul_inf), .mul_zero(b_mul_zero),
        .busy(b_busy), .grant_id(b_grant_id), .op_count(b_op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        a_req_valid = '0; b_req_valid = '0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        a_req_valid = 4'b0001; a_resp_ready = '0; a_req_in1 = '0; a_req_in2 = '0;
        b_req_valid = 4'b0001; b_resp_ready = '0; b_req_in1 = '0; b_req_in2 = '0;
        #1;
        checks++; if (a_req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", a_req_ready); end
        repeat (2) tick();
        checks++; if (a_busy !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b/%b exp=0/0", a_busy, b_busy); end
        checks++; if (a_resp_valid !== 4'b0000) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0000", a_resp_valid); end
        checks++; if (a_op_count !== 32'd0 || a_grant_id !== 2'd0) begin errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", a_op_count, a_grant_id); end
        checks++; if (a_mul_in1 !== 16'h0 || a_mul_in2 !== 16'h0 || a_mul_start !== 1'b0) begin errors++; $display("FAIL reset_mul_if got=%h/%h/%b exp=0/0/0", a_mul_in1, a_mul_in2, a_mul_start); end
        a_req_valid = '0; b_req_valid = '0;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_basic;
        a_resp_ready = 4'b1111;
        a_req_in1[15:0] = 16'h4000; a_req_in2[15:0] = 16'h4800;
        a_req_valid = 4'b0001;
        #1;
        checks++; if (a_req_ready !== 4'b0001) begin errors++; $display("FAIL basic_req_ready got=%b exp=0001", a_req_ready); end
        tick();
        a_req_valid = '0;
        checks++; if (a_req_ready !== 4'b0000 || a_busy !== 1'b1) begin errors++; $display("FAIL basic_exec_state got=%b/%b exp=0000/1", a_req_ready, a_busy); end
        checks++; if (a_mul_start !== 1'b1) begin errors++; $display("FAIL basic_mul_start got=%b exp=1", a_mul_start); end
        checks++; if (a_mul_in1 !== 16'h4000 || a_mul_in2 !== 16'h4800) begin errors++; $display("FAIL basic_mul_in got=%h/%h exp=4000/4800", a_mul_in1, a_mul_in2); end
        checks++; if (a_resp_valid !== 4'b0000) begin errors++; $display("FAIL basic_early_resp got=%b exp=0000", a_resp_valid); end
        tick();
        checks++; if (a_resp_valid !== 4'b0001) begin errors++; $display("FAIL basic_resp_valid got=%b exp=0001", a_resp_valid); end
        checks++; if (a_resp_out !== 16'h4800 || a_resp_inf !== 1'b0 || a_resp_zero !== 1'b0) begin errors++; $display("FAIL basic_result got=%h/%b/%b exp=4800/0/0", a_resp_out, a_resp_inf, a_resp_zero); end
        checks++; if (a_mul_start !== 1'b0) begin errors++; $display("FAIL basic_start_once got=%b exp=0", a_mul_start); end
        tick();
        checks++; if (a_op_count !== 32'd1 || a_resp_valid !== 4'b0000 || a_busy !== 1'b0) begin errors++; $display("FAIL basic_done got=%0d/%b/%b exp=1/0000/0", a_op_count, a_resp_valid, a_busy); end
    endtask

    task automatic test_round_robin;
        logic [3:0] oh;
        int         exp;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a_req_in1[i*N +: N] = 16'h4000;
            a_req_in2[i*N +: N] = 16'h1100 + 16'(i);
        end
        a_resp_ready = 4'b1111;
        a_req_valid  = 4'b1111;
        #1;
        for (int g = 0; g < 6; g++) begin
            exp = g % 4;
            oh  = 4'b0001 << exp;
            checks++; if (a_req_ready !== oh) begin errors++; $display("FAIL rr_grant%0d_ready got=%b exp=%b", g, a_req_ready, oh); end
            tick();
            checks++; if (a_grant_id !== IDW'(exp)) begin errors++; $display("FAIL rr_grant%0d_id got=%0d exp=%0d", g, a_grant_id, exp); end
            tick();
            checks++; if (a_resp_valid !== oh || a_resp_out !== 16'h1100 + 16'(exp)) begin errors++; $display("FAIL rr_grant%0d_resp got=%b/%h exp=%b/%h", g, a_resp_valid, a_resp_out, oh, 16'h1100 + 16'(exp)); end
            tick();
        end
        a_req_valid = '0;
        checks++; if (a_op_count !== 32'd6) begin errors++; $display("FAIL rr_op_count got=%0d exp=6", a_op_count); end
    endtask

    task automatic test_backpressure;
        do_reset();
        a_req_in1[15:0]  = 16'h1234; a_req_in2[15:0]  = 16'h00FF;
        a_req_in1[31:16] = 16'h4000; a_req_in2[31:16] = 16'h2222;
        a_resp_ready = 4'b0000;
        a_req_valid  = 4'b0011;
        #1;
        checks++; if (a_req_ready !== 4'b0001) begin errors++; $display("FAIL bp_first_grant got=%b exp=0001", a_req_ready); end
        tick();
        tick();
        a_resp_ready = 4'b1110;
        for (int c = 0; c < 10; c++) begin
            checks++; if (a_resp_valid !== 4'b0001 || a_resp_out !== 16'hED34) begin errors++; $display("FAIL bp_hold%0d got=%b/%h exp=0001/ed34", c, a_resp_valid, a_resp_out); end
            checks++; if (a_req_ready !== 4'b0000 || a_busy !== 1'b1) begin errors++; $display("FAIL bp_blocked%0d got=%b/%b exp=0000/1", c, a_req_ready, a_busy); end
            tick();
        end
        a_resp_ready = 4'b0001;
        tick();
        checks++; if (a_req_ready !== 4'b0010 || a_op_count !== 32'd1) begin errors++; $display("FAIL bp_next_grant got=%b/%0d exp=0010/1", a_req_ready, a_op_count); end
        tick();
        a_req_valid = '0;
        checks++; if (a_grant_id !== 2'd1) begin errors++; $display("FAIL bp_grant_id got=%0d exp=1", a_grant_id); end
        tick();
        checks++; if (a_resp_valid !== 4'b0010 || a_resp_out !== 16'h2222) begin errors++; $display("FAIL bp_second_resp got=%b/%h exp=0010/2222", a_resp_valid, a_resp_out); end
        a_resp_ready = 4'b0010;
        tick();
        checks++; if (a_op_count !== 32'd2) begin errors++; $display("FAIL bp_op_count got=%0d exp=2", a_op_count); end
    endtask

    task automatic test_zero;
        a_req_in1[47:32] = 16'h0000; a_req_in2[47:32] = 16'h0000;
        a_req_in1[63:48] = 16'h4000; a_req_in2[63:48] = 16'h4000;
        a_resp_ready = 4'b1111;
        a_req_valid  = 4'b0100;
        #1;
        checks++; if (a_req_ready !== 4'b0100) begin errors++; $display("FAIL zero_ready got=%b exp=0100", a_req_ready); end
        tick();
        a_req_valid = 4'b1000;
        #1;
        checks++; if (a_req_ready !== 4'b0000 || a_grant_id !== 2'd2) begin errors++; $display("FAIL zero_exec_ignore got=%b/%0d exp=0000/2", a_req_ready, a_grant_id); end
        tick();
        checks++; if (a_resp_valid !== 4'b0100 || a_resp_out !== 16'h0000 || a_resp_zero !== 1'b1 || a_resp_inf !== 1'b0) begin errors++; $display("FAIL zero_result got=%b/%h/%b/%b exp=0100/0000/1/0", a_resp_valid, a_resp_out, a_resp_zero, a_resp_inf); end
        tick();
        checks++; if (a_op_count !== 32'd3 || a_req_ready !== 4'b1000) begin errors++; $display("FAIL zero_count got=%0d/%b exp=3/1000", a_op_count, a_req_ready); end
        tick();
        a_req_valid = '0;
        tick();
        checks++; if (a_resp_valid !== 4'b1000 || a_resp_out !== 16'h4000 || a_resp_zero !== 1'b0) begin errors++; $display("FAIL last_req_result got=%b/%h/%b exp=1000/4000/0", a_resp_valid, a_resp_out, a_resp_zero); end
        tick();
        checks++; if (a_op_count !== 32'd4) begin errors++; $display("FAIL last_req_count got=%0d exp=4", a_op_count); end
    endtask

    task automatic test_nar_lat3;
        b_req_in1[47:32] = 16'h8000; b_req_in2[47:32] = 16'h4000;
        b_resp_ready = 4'b0100;
        b_req_valid  = 4'b0100;
        #1;
        checks++; if (b_req_ready !== 4'b0100) begin errors++; $display("FAIL nar_ready got=%b exp=0100", b_req_ready); end
        tick();
        b_req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            checks++; if (b_mul_in1 !== 16'h8000 || b_mul_in2 !== 16'h4000 || b_busy !== 1'b1) begin errors++; $display("FAIL nar_hold%0d got=%h/%h/%b exp=8000/4000/1", c, b_mul_in1, b_mul_in2, b_busy); end
            checks++; if (b_mul_start !== (c == 0) || b_resp_valid !== 4'b0000) begin errors++; $display("FAIL nar_exec%0d got=%b/%b exp=%b/0000", c, b_mul_start, b_resp_valid, c == 0); end
            tick();
        end
        checks++; if (b_resp_valid !== 4'b0100 || b_grant_id !== 2'd2) begin errors++; $display("FAIL nar_resp_valid got=%b/%0d exp=0100/2", b_resp_valid, b_grant_id); end
        checks++; if (b_resp_out !== 16'h8000 || b_resp_inf !== 1'b1 || b_resp_zero !== 1'b0) begin errors++; $display("FAIL nar_result got=%h/%b/%b exp=8000/1/0", b_resp_out, b_resp_inf, b_resp_zero); end
        tick();
        checks++; if (b_op_count !== 32'd1 || b_busy !== 1'b0) begin errors++; $display("FAIL nar_done got=%0d/%b exp=1/0", b_op_count, b_busy); end
    endtask

    task automatic test_async_reset;
        b_req_in1[63:48] = 16'h4000; b_req_in2[63:48] = 16'h3333;
        b_req_in1[15:0]  = 16'h4000; b_req_in2[15:0]  = 16'h5555;
        b_resp_ready = 4'b1111;
        b_req_valid  = 4'b1000;
        #1;
        tick();
        b_req_valid = '0;
        tick();
        checks++; if (b_busy !== 1'b1 || b_mul_start !== 1'b0 || b_grant_id !== 2'd3) begin errors++; $display("FAIL arst_pre got=%b/%b/%0d exp=1/0/3", b_busy, b_mul_start, b_grant_id); end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (b_busy !== 1'b0 || b_resp_valid !== 4'b0000) begin errors++; $display("FAIL arst_immediate got=%b/%b exp=0/0000", b_busy, b_resp_valid); end
        checks++; if (b_mul_in1 !== 16'h0 || b_grant_id !== 2'd0 || b_op_count !== 32'd0) begin errors++; $display("FAIL arst_clear got=%h/%0d/%0d exp=0/0/0", b_mul_in1, b_grant_id, b_op_count); end
        #2;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++; if (b_resp_valid !== 4'b0000 || b_busy !== 1'b0) begin errors++; $display("FAIL arst_no_resp%0d got=%b/%b exp=0000/0", c, b_resp_valid, b_busy); end
        end
        b_req_valid = 4'b1001;
        #1;
        checks++; if (b_req_ready !== 4'b0001) begin errors++; $display("FAIL arst_regrant got=%b exp=0001", b_req_ready); end
        tick();
        b_req_valid = '0;
        checks++; if (b_grant_id !== 2'd0) begin errors++; $display("FAIL arst_grant_id got=%0d exp=0", b_grant_id); end
        repeat (4) tick();
        checks++; if (b_resp_valid !== 4'b0001 || b_resp_out !== 16'h5555) begin errors++; $display("FAIL arst_after_resp got=%b/%h exp=0001/5555", b_resp_valid, b_resp_out); end
        tick();
        checks++; if (b_op_count !== 32'd1) begin errors++; $display("FAIL arst_after_count got=%0d exp=1", b_op_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_backpressure();
        test_zero();
        test_nar_lat3();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
